// File: rtl/sat_accum_if.sv
// Valid/ready sample stream in, block total stream out.
// The master drives samples and out_ready; the slave is the accumulator.
interface sat_accum_if #(
   parameter int WIDTH = 12,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       mode;
   logic [CNT_W-1:0] len;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_sat;
   logic             busy;

   modport master (
      output in_valid, in_data, mode, len, out_ready,
      input  in_ready, out_valid, out_data, out_sat, busy
   );

   modport slave (
      input  in_valid, in_data, mode, len, out_ready,
      output in_ready, out_valid, out_data, out_sat, busy
   );
endinterface

// File: rtl/sat_accum.sv
// Block accumulator: sums len samples with per-step unsigned/signed
// saturation or wrap, then holds the total until downstream takes it.
module sat_accum #(
   parameter int WIDTH = 12,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   sat_accum_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W:0]   cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] len_q, len_d;

   logic [1:0]       step_mode;
   logic [CNT_W-1:0] step_len;
   logic [CNT_W:0]   eff_len;
   logic [CNT_W:0]   cnt_nxt;
   logic [WIDTH-1:0] base;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] step_res;
   logic             step_sat;
   logic             in_xfer;

   // The first sample of a block sees live mode/len and a zero base
   always_comb begin
      step_mode = (state_q == IDLE) ? bus.mode : mode_q;
      step_len  = (state_q == IDLE) ? bus.len : len_q;
      base      = (state_q == IDLE) ? '0 : acc_q;
      eff_len   = (step_len == '0) ? {1'b1, {CNT_W{1'b0}}}
                                   : {1'b0, step_len};
      cnt_nxt   = (state_q == IDLE) ? {{CNT_W{1'b0}}, 1'b1}
                                    : cnt_q + {{CNT_W{1'b0}}, 1'b1};
      sum       = {1'b0, base} + {1'b0, bus.in_data};
      step_res  = sum[WIDTH-1:0];
      step_sat  = 1'b0;
      if (!step_mode[1]) begin
         if (!step_mode[0]) begin
            if (sum[WIDTH]) begin
               step_res = '1;
               step_sat = 1'b1;
            end
         end else if (base[WIDTH-1] == bus.in_data[WIDTH-1] &&
                      sum[WIDTH-1] != base[WIDTH-1]) begin
            step_res = {base[WIDTH-1], {(WIDTH-1){~base[WIDTH-1]}}};
            step_sat = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      mode_d  = mode_q;
      len_d   = len_q;
      in_xfer = bus.in_valid && (state_q != HOLD);
      case (state_q)
         IDLE, ACCUM: begin
            if (in_xfer) begin
               acc_d = step_res;
               sat_d = sat_q | step_sat;
               cnt_d = cnt_nxt;
               if (state_q == IDLE) begin
                  mode_d = bus.mode;
                  len_d  = bus.len;
               end
               state_d = (cnt_nxt == eff_len) ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         mode_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
      end
   end

   assign bus.in_ready  = (state_q != HOLD);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = acc_q;
   assign bus.out_sat   = sat_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/sat_accum.md
Name: sat_accum

Overview:
Sequential block-accumulator that sits directly downstream of the 12-bit saturating adder datapath. It consumes a valid/ready stream of 12-bit samples and sums a block of N samples. Each step uses the same three adder modes: unsigned saturation, signed saturation, or wrap. It then presents the block total and a sticky saturation flag on a valid/ready output port.

Parameters:
WIDTH, 12, sample/accumulator width in bits
CNT_W, 4, width of block-length field; len=0 means 2**CNT_W samples

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream sample valid
in_ready  output  1  block can accept a sample this cycle
in_data  input  WIDTH  sample (unsigned or two's complement per mode)
mode  input  2  00 unsigned sat, 01 signed sat, 1x normal wrap addition
len  input  CNT_W  samples per block; 0 encodes 2**CNT_W
out_valid  output  1  block result available
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  accumulated block total
out_sat  output  1  at least one step in this block saturated (0 in mode 1x)
busy  output  1  high in ACCUM or HOLD

Behaviour:
- Clock is clk. Reset is synchronous and active-high. On reset: state=IDLE, acc=0, cnt=0, sat_flag=0, mode_q=0, len_q=0.
- Reset output values: in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0.
- Reset has priority over every other event, including mid-block and during HOLD. A partial block is discarded with no output.
- Transfer rule: a transfer occurs when valid && ready at a rising edge. out_data and out_sat must stay stable while out_valid && !out_ready.
- States:
  - IDLE: in_ready=1. On input transfer: latch mode_q=mode and len_q=len; acc=step(0, in_data); cnt=1. If the effective length is 1, go to HOLD; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On input transfer: acc=step(acc, in_data); cnt=cnt+1. When the new cnt equals the effective length, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, out_data=acc, out_sat=sat_flag. On output transfer: go to IDLE and clear acc, cnt and sat_flag.
- mode and len are sampled only on the first sample of a block. Changes during ACCUM are ignored.
- Effective length is len_q when len_q != 0, otherwise 2**CNT_W. cnt is CNT_W+1 bits wide so that 2**CNT_W is representable.
- step(x, s): r = {1'b0,x} + {1'b0,s}, WIDTH+1 bits.
  - Mode 00: if r[WIDTH]=1, the result is all ones and sat_flag is set. Otherwise the result is r[WIDTH-1:0].
  - Mode 01: overflow when x sign == s sign and r[WIDTH-1] != x sign. On positive overflow the result is 0x7FF; on negative overflow it is 0x800. Either sets sat_flag. Otherwise the result is r[WIDTH-1:0].
  - Mode 1x: the result is r[WIDTH-1:0] and sat_flag is unchanged.
- Saturation is applied per step, not once at the end. A clamped intermediate feeds the next step. sat_flag is sticky for the whole block.
- Latency: out_valid rises the cycle after the last sample's transfer edge.
- No input is accepted in HOLD; back-to-back blocks need at least one cycle between them. The first sample of the next block can transfer on the cycle after the output transfer.
- in_valid low in ACCUM stalls the block indefinitely with no timeout. acc and cnt hold their values.

Test Plan:
1. Mode 00, len=3, samples 0x800, 0x700, 0x100 -> intermediate 0xF00, then carry. Required: out_data=0xFFF, out_sat=1, out_valid rises 1 cycle after the third transfer.
2. Mode 01, len=2, samples 0x7F0, 0x020 -> out_data=0x7FF, out_sat=1. Then mode 01, len=2, samples 0x800, 0xFFF -> out_data=0x800, out_sat=1.
3. Mode 10, len=2, samples 0xFFF, 0x002 -> out_data=0x001, out_sat=0. Repeat with mode=11: identical result.
4. len=0, mode 10, 16 samples of 0x001 with in_valid toggling every other cycle -> exactly 16 transfers, then out_data=0x010. in_ready=0 after the 16th transfer.
5. Block completes with out_ready held low 5 cycles -> out_data and out_sat stable, in_ready=0, in_valid ignored. out_ready=1 -> IDLE the next cycle with in_ready=1. mode/len changed mid-block -> no effect on the result.
6. Assert reset after 2 of 4 samples (mode 00) -> next cycle all outputs at reset values and no out_valid. A new block of 0x001 x4 yields 0x004, out_sat=0.
